// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: shared constants and state type for the shift arbiter
package shift_arb_pkg;
  localparam logic MODE_LSR = 1'b0;
  localparam logic MODE_ROR = 1'b1;
  localparam int ID_W = 2;
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
endpackage

// File: rtl/shift_unit.sv
// shift_unit: 8-bit logical right shift / rotate right as a 4-2-1 mux cascade
module shift_unit
  import shift_arb_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] amt,
  input  logic       mode,
  output logic [7:0] result
);
  logic rot;
  logic [7:0] s4, s2;
  always_comb begin
    rot = mode == MODE_ROR;
    s4 = amt[2] ? {rot ? data[3:0] : 4'h0, data[7:4]} : data;
    s2 = amt[1] ? {rot ? s4[1:0] : 2'b00, s4[7:2]} : s4;
    result = amt[0] ? {rot & s2[0], s2[7:1]} : s2;
  end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one shift_unit among NREQ
// requesters, with a registered valid/ready result port
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ*3-1:0] req_amt,
  input  logic [NREQ-1:0]   req_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [ID_W-1:0]   rsp_id
);
  state_t state;
  logic [ID_W-1:0] rr_ptr, win, idx;
  logic found, can_accept, grant;
  logic [N-1:0] sel_data, shifted;
  logic [2:0] sel_amt;
  logic sel_mode;
  // first valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign rsp_valid = state == ST_FULL;
  assign can_accept = !rsp_valid || rsp_ready;
  assign grant = found && can_accept && !rst;
  assign req_ready = grant ? NREQ'(1) << win : '0;
  assign sel_data = req_data[win*N +: N];
  assign sel_amt = req_amt[win*3 +: 3];
  assign sel_mode = req_mode[win];
  shift_unit u_shift (
    .data(sel_data),
    .amt(sel_amt),
    .mode(sel_mode),
    .result(shifted)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      rr_ptr <= '0;
      rsp_data <= '0;
      rsp_id <= '0;
    end else if (grant) begin
      state <= ST_FULL;
      rr_ptr <= ID_W'((32'(win) + 1) % NREQ);
      rsp_data <= shifted;
      rsp_id <= win;
    end else if (rsp_ready) begin
      state <= ST_EMPTY;
    end
  end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one 8-bit right-shift/rotate unit between up to four requesters. Each requester uses a valid/ready handshake to present a data word, a 3-bit shift amount and a mode bit. The arbiter grants one requester per cycle, registers the shifted result with the requester ID, and holds it on a valid/ready output port until it is consumed. It sits between the datapath clients and the shared shifter, so only one shifter instance exists in the design.

## Interface
- `NREQ`, 4: number of requesters; legal values 2..4.
- `N`, 8: data width; fixed at 8 in this revision.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NREQ: per-requester request valid.
- `req_ready` output NREQ: per-requester accept, one-hot or zero.
- `req_data` input NREQ*N: packed data; requester i occupies bits `[i*N +: N]`.
- `req_amt` input NREQ*3: packed shift amount, 0..7.
- `req_mode` input NREQ: 0 = logical right shift (zero fill), 1 = rotate right.
- `rsp_valid` output 1: result register holds a valid result.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output N: shifted or rotated result.
- `rsp_id` output 2: index of the requester that produced the result.

## Operation
- FSM has 2 states: EMPTY (result register free) and FULL (result held).
- A request can be accepted when `can_accept = (state==EMPTY) | (rsp_valid & rsp_ready)`.
- Arbitration:
  - Round-robin pointer `rr_ptr` (2 bits) holds the highest-priority index.
  - Search order is `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - The first valid requester wins. `req_ready[winner]=1` only when `can_accept`.
- A handshake occurs when `req_valid[i] & req_ready[i]`.
- On a handshake:
  - Result register loads `shift(req_data[i], req_amt[i], req_mode[i])` and `rsp_id` loads i.
  - State goes to FULL and `rr_ptr` goes to `(i+1) mod NREQ`.
- Consume without a new grant (`rsp_valid & rsp_ready`, no new handshake): state goes to EMPTY.
- Consume and grant in the same cycle: state stays FULL and the register reloads. This gives full throughput.
- `rr_ptr` is unchanged when there is no grant.
- Shift function:
  - Logical mode: `data >> amt`, with zeros shifted into the MSBs.
  - Rotate mode: bits shifted out of bit 0 re-enter at bit 7.
  - `amt=0` passes data through unchanged in both modes.
- `rsp_data` and `rsp_id` stay stable while `rsp_valid & !rsp_ready`.
- `req_ready` is a function of `req_valid`, `state`, `rsp_ready` and `rr_ptr`. The path from `rsp_ready` to `req_ready` is combinational.
- Inputs of a requester that is not granted are ignored. A requester may drop `req_valid` before it is granted.

## Timing
- Reset values:
  - state = EMPTY, `rr_ptr` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - `req_ready` = 0 during the reset cycle.
- Latency: a handshake in cycle T gives `rsp_valid=1` with the result in cycle T+1.
- Throughput: 1 result per cycle while `rsp_ready` stays high.
- Backpressure: with FULL and `rsp_ready=0`, all `req_ready` are 0 and the held result does not change.
- `rst` asserted mid-operation: the held result is discarded and `rsp_valid` = 0 in the next cycle. No handshake is honoured in the reset cycle.
- Single requester valid continuously with no contention: it is granted every cycle that `can_accept` is true.

## Structure
- Shared package `shift_arb_pkg`:
  - Constants `MODE_LSR=1'b0` and `MODE_ROR=1'b1`.
  - `ID_W=2`.
  - State enum `{ST_EMPTY, ST_FULL}`.
- One combinational sub-module `shift_unit` with inputs data[7:0], amt[2:0], mode and output result[7:0]. It is built as three cascaded stages (4, 2, 1) of 2:1 muxes. The fill source is 0 or the wrapped bits, selected by mode.
- The top level contains:
  - The arbiter, with a rotate-priority search over `req_valid` by `rr_ptr`.
  - The FSM.
  - The result register.
  - A single `shift_unit` instance fed by a mux of the winner's fields.

## Test plan
- **Shift/rotate correctness** (requester 0 only, `rsp_ready=1`):
  - 0x10, amt 4, LSR → 0x01.
  - 0x80, amt 2, LSR → 0x20.
  - 0x81, amt 1, ROR → 0xC0.
  - 0xF0, amt 4, ROR → 0x0F.
  - 0xA5, amt 0 → 0xA5.
  - Each result appears with `rsp_id=0` one cycle after its handshake.
- **Round-robin fairness**: all 4 `req_valid` held high, `rsp_ready=1`, distinct data per requester. Grant order is 0,1,2,3,0,… with one grant per cycle and `rsp_id` sequence 0,1,2,3,0.
- **Pointer advance**: only requesters 1 and 3 valid, `rr_ptr=0`. Grant order is 1, 3, 1. Then requester 2 also asserts while `rr_ptr=2`: requester 2 is granted before 3.
- **Backpressure**: grant requester 2 with 0x3C amt 2 ROR → 0x0F, then hold `rsp_ready=0` for 5 cycles. `rsp_data` stays 0x0F and all `req_ready=0`. On the cycle `rsp_ready` rises, the next waiting requester is granted in that same cycle.
- **Drain**: a single request, then no valid requests. `rsp_valid` is high for exactly one cycle with `rsp_ready=1`, then state returns to EMPTY.
- **Reset mid-operation**: FULL with `rsp_ready=0`, assert `rst` for 1 cycle. The next cycle shows `rsp_valid=0`, `rsp_data=0`, `rr_ptr=0`, and the first post-reset grant goes to requester 0 when all are valid.
